// File: rtl/mmio_console.sv
// rtl/mmio_console.sv - MMIO character console: packed-word writes unpacked MSB-first into a byte FIFO drained over valid/ready.
module mmio_console #(
  parameter int          MEMORY_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR    = 32'he1000100,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sel_in,
  input  logic [MEMORY_WIDTH-1:0] addr_in,
  input  logic [MEMORY_WIDTH-1:0] data_in,
  input  logic [3:0]              wb_in,
  output logic [MEMORY_WIDTH-1:0] data_out,
  output logic                    irq,
  output logic [7:0]              char_data,
  output logic                    char_valid,
  input  logic                    char_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, UNPACK} state_t;

  state_t        state, state_next;
  logic [31:0]   stage_data;
  logic [3:0]    mask, mask_next, new_mask;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ie, ovf;

  logic          hit, is_write, data_wr, ctrl_wr;
  logic [1:0]    offset, lane;
  logic          full, busy, empty, pop, push, load, ovf_set;
  logic [7:0]    push_byte;
  logic [31:0]   status, rd_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^addr_in[1:0];

  assign hit      = sel_in && (addr_in[31:4] == BASE_ADDR[31:4]);
  assign offset   = addr_in[3:2];
  assign is_write = |wb_in;
  assign data_wr  = hit && is_write && (offset == 2'd0);
  assign ctrl_wr  = hit && (offset == 2'd2) && wb_in[0];

  assign full       = (count == CW'(FIFO_DEPTH));
  assign busy       = (state == UNPACK);
  assign empty      = (count == '0) && !busy;
  assign char_valid = (count != '0);
  assign char_data  = mem[rd_ptr];
  assign pop        = char_valid && char_ready;

  assign status = {16'h0, 8'(count), 4'h0, ovf, busy, full, empty};

  // Strobed lanes holding NUL are dropped before they ever reach the unpacker.
  always_comb begin
    new_mask = '0;
    for (int i = 0; i < 4; i++)
      new_mask[i] = wb_in[i] && (data_in[8*i +: 8] != 8'h00);
  end

  always_comb begin
    lane = 2'd0;
    if (mask[3])      lane = 2'd3;
    else if (mask[2]) lane = 2'd2;
    else if (mask[1]) lane = 2'd1;
    push_byte = stage_data[8*lane +: 8];
  end

  always_comb begin
    state_next = state;
    mask_next  = mask;
    push       = 1'b0;
    load       = 1'b0;
    ovf_set    = 1'b0;
    case (state)
      IDLE: begin
        if (data_wr) begin
          load      = 1'b1;
          mask_next = new_mask;
          if (|new_mask) state_next = UNPACK;
        end
      end
      UNPACK: begin
        ovf_set = data_wr;
        // A full FIFO still takes a byte when the sink frees a slot this cycle.
        if (!full || pop) begin
          push      = 1'b1;
          mask_next = mask & ~(4'b0001 << lane);
          if (mask_next == 4'b0000) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (hit && !is_write) begin
      case (offset)
        2'd1:    rd_data = status;
        2'd2:    rd_data = {31'h0, ie};
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      stage_data <= '0;
      mask       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ie         <= 1'b0;
      ovf        <= 1'b0;
      irq        <= 1'b0;
      data_out   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      state    <= state_next;
      mask     <= mask_next;
      data_out <= rd_data;
      irq      <= ie && empty;
      if (load) stage_data <= data_in;
      if (push) begin
        mem[wr_ptr] <= push_byte;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)                  ovf <= 1'b1;
      else if (ctrl_wr && data_in[1]) ovf <= 1'b0;
      if (ctrl_wr) ie <= data_in[0];
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// tb/tb_mmio_console.sv - Scoreboard bench for mmio_console against a queue-based console model.
module tb_mmio_console;

  localparam logic [31:0] BASE  = 32'he1000100;
  localparam int          DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sel_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  wb_in = '0;
  logic        char_ready = 1'b0;
  logic [31:0] data_out;
  logic        irq;
  logic [7:0]  char_data;
  logic        char_valid;

  always #5 clock = ~clock;

  mmio_console #(.MEMORY_WIDTH(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .sel_in(sel_in), .addr_in(addr_in),
    .data_in(data_in), .wb_in(wb_in), .data_out(data_out), .irq(irq),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  m_fifo[$];
  logic [7:0]  m_stage[$];
  logic [7:0]  exp_chars[$];
  logic [31:0] exp_rd[$];
  logic        m_ie = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_irq = 1'b0;
  bit          started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the console as a pending-character list feeding a character queue.
  always @(posedge clock) begin
    logic        hit, pop, push, busy, emp;
    logic [1:0]  off;
    logic [31:0] rd;
    started = 1;
    if (!reset) begin
      m_fifo.delete();
      m_stage.delete();
      exp_chars.delete();
      m_ie  = 1'b0;
      m_ovf = 1'b0;
      m_irq = 1'b0;
      exp_rd.push_back(32'h0);
    end else begin
      hit  = sel_in && (addr_in[31:4] == BASE[31:4]);
      off  = addr_in[3:2];
      busy = (m_stage.size() != 0);
      emp  = (m_fifo.size() == 0) && !busy;
      rd   = 32'h0;
      if (hit && wb_in == 4'h0) begin
        if (off == 2'd1)
          rd = {16'h0, 8'(m_fifo.size()), 4'h0, m_ovf, busy, (m_fifo.size() == DEPTH), emp};
        else if (off == 2'd2)
          rd = {31'h0, m_ie};
      end
      exp_rd.push_back(rd);
      m_irq = m_ie && emp;
      pop  = (m_fifo.size() != 0) && char_ready;
      push = busy && ((m_fifo.size() < DEPTH) || pop);
      if (pop) void'(m_fifo.pop_front());
      if (push) m_fifo.push_back(m_stage.pop_front());
      if (hit && wb_in != 4'h0 && off == 2'd0) begin
        if (busy) m_ovf = 1'b1;
        else
          for (int i = 3; i >= 0; i--)
            if (wb_in[i] && data_in[8*i +: 8] != 8'h00) begin
              m_stage.push_back(data_in[8*i +: 8]);
              exp_chars.push_back(data_in[8*i +: 8]);
            end
      end
      if (hit && off == 2'd2 && wb_in[0]) begin
        m_ie = data_in[0];
        if (data_in[1]) m_ovf = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      if (exp_rd.size() != 0) check("data_out", data_out, exp_rd.pop_front());
      check("irq", {31'h0, irq}, {31'h0, m_irq});
      check("char_valid", {31'h0, char_valid}, {31'h0, m_fifo.size() != 0});
      if (reset && char_valid && char_ready) begin
        if (exp_chars.size() == 0) check("unexpected_char", {24'h0, char_data}, 32'hFFFF_FFFF);
        else check("char_data", {24'h0, char_data}, {24'h0, exp_chars.pop_front()});
      end
    end
  end

  task automatic access(input logic s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    sel_in = s; addr_in = a; data_in = d; wb_in = w;
    @(posedge clock); #1;
    sel_in = 1'b0; addr_in = '0; data_in = '0; wb_in = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    access(1, BASE + 4, 0, 4'h0);
    idle(1);

    char_ready = 1'b1;
    access(1, BASE, 32'h4869210A, 4'hF);
    idle(6);
    access(1, BASE, 32'h41004243, 4'hB);
    idle(6);

    char_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      access(1, BASE, 32'h30313233 + 32'h04040404 * k, 4'hF);
      idle(6);
    end
    access(1, BASE + 4, 0, 4'h0);
    idle(1);
    char_ready = 1'b1;
    idle(30);

    access(1, BASE, 32'h61626364, 4'hF);
    access(1, BASE, 32'h65666768, 4'hF);
    access(1, BASE + 4, 0, 4'h0);
    idle(6);
    access(1, BASE + 8, 32'h2, 4'h1);
    access(1, BASE + 4, 0, 4'h0);

    access(1, BASE + 8, 32'h1, 4'h1);
    access(1, BASE + 8, 0, 4'h0);
    access(1, BASE, 32'h00000058, 4'hF);
    idle(6);
    access(1, BASE, 32'h71727374, 4'hF);
    idle(1);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    access(1, BASE + 4, 0, 4'h0);
    access(1, BASE + 12, 32'hFFFFFFFF, 4'hF);
    access(1, BASE + 12, 0, 4'h0);

    repeat (400) begin
      char_ready = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 4; b++) d[8*b +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      case ($urandom_range(0, 6))
        0: idle(1);
        1: access(1, BASE + 4 * $urandom_range(0, 3), 0, 4'h0);
        2: access(1, BASE, d, 4'($urandom));
        3: access(1, BASE + 8, {30'h0, 2'($urandom)}, 4'($urandom));
        4: access(1, BASE + 16 + 4 * $urandom_range(0, 3), d, 4'($urandom));
        5: access(0, BASE + 4 * $urandom_range(0, 3), d, 4'($urandom));
        default: idle($urandom_range(1, 6));
      endcase
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
      end
    end

    char_ready = 1'b1;
    idle(40);
    check("drained", exp_chars.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
